// File: rtl/token_unembedding_pkg.sv
// Shared definitions for the token unembedding slice.
// Holds the vocabulary/vector geometry, the score width, the FSM state
// encoding and the fixed embedding-table function. token_embedding can
// reuse the same table through emb_elem().
package token_unembedding_pkg;

  localparam int N_TOKENS  = 16;
  localparam int D_MODEL   = 4;
  localparam int DW        = 8;
  localparam int SCORE_W   = 18;
  localparam int ID_W      = $clog2(N_TOKENS);
  // One extra bit so the row counter can reach N_TOKENS (the drain step).
  localparam int ROW_CNT_W = ID_W + 1;
  localparam int EMB_MAG   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Element k of token t: +EMB_MAG when bit k of t is set, else -EMB_MAG.
  function automatic logic signed [DW-1:0] emb_elem(input logic [ID_W-1:0] t,
                                                    input int unsigned k);
    logic signed [DW-1:0] pos_val;
    pos_val = DW'(EMB_MAG);
    return t[k[$clog2(ID_W)-1:0]] ? pos_val : -pos_val;
  endfunction

endpackage

// File: rtl/token_unembedding_mac.sv
// token_score_mac: combinational dot product of the captured input vector
// with one row of the fixed embedding table.
// Ports:
//   row    - token index whose embedding row is scored
//   vec    - packed input vector, element k at [k*DW +: DW], signed
//   score  - full-precision signed dot product (no saturation/truncation)
module token_score_mac
  import token_unembedding_pkg::*;
(
  input  logic [ID_W-1:0]            row,
  input  logic [D_MODEL*DW-1:0]      vec,
  output logic signed [SCORE_W-1:0]  score
);

  logic signed [SCORE_W-1:0] prod [D_MODEL];
  logic signed [SCORE_W-1:0] pair_sum [D_MODEL/2];

  genvar gi;
  generate
    for (gi = 0; gi < D_MODEL; gi++) begin : g_mul
      logic signed [DW-1:0] elem;
      logic signed [DW-1:0] weight;
      assign elem   = vec[gi*DW +: DW];
      assign weight = emb_elem(row, gi);
      // Sign-extend both operands to the score width before multiplying.
      assign prod[gi] = SCORE_W'(elem) * SCORE_W'(weight);
    end

    // Two-level adder tree: pairwise sums, then the final add.
    for (gi = 0; gi < D_MODEL/2; gi++) begin : g_pair
      assign pair_sum[gi] = prod[2*gi] + prod[2*gi+1];
    end
  endgenerate

  assign score = pair_sum[0] + pair_sum[1];

endmodule

// File: rtl/token_unembedding.sv
// token_unembedding: argmax over the fixed embedding table.
// Captures one input vector, scores all N_TOKENS rows one per cycle, and
// presents the lowest-index token with the highest dot product.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - input handshake (accepted only in IDLE)
//   vector0..vector3    - signed input vector elements
//   out_valid/out_ready - result handshake (held in DONE until taken)
//   token_id, score     - winning token index and its dot product
module token_unembedding
  import token_unembedding_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DW-1:0]       vector0,
  input  logic signed [DW-1:0]       vector1,
  input  logic signed [DW-1:0]       vector2,
  input  logic signed [DW-1:0]       vector3,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_W-1:0]            token_id,
  output logic signed [SCORE_W-1:0]  score
);

  state_e                    state_reg, state_next;
  logic                      in_ready_reg;
  logic [ROW_CNT_W-1:0]      row_cnt_reg;
  logic [D_MODEL*DW-1:0]     vec_reg;
  logic signed [SCORE_W-1:0] mac_score;
  // One-deep stage between the MAC and the comparator so the multiply and
  // the compare sit in different cycles; SCAN therefore lasts one extra
  // cycle to drain the last row.
  logic                      stage_valid_reg;
  logic [ID_W-1:0]           stage_id_reg;
  logic signed [SCORE_W-1:0] stage_score_reg;
  logic [ID_W-1:0]           best_id_reg;
  logic signed [SCORE_W-1:0] best_score_reg;
  logic                      scan_last;

  assign scan_last = (row_cnt_reg == ROW_CNT_W'(N_TOKENS));

  token_score_mac u_mac (
    .row   (row_cnt_reg[ID_W-1:0]),
    .vec   (vec_reg),
    .score (mac_score)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid && in_ready_reg) state_next = SCAN;
      SCAN:    if (scan_last)                state_next = DONE;
      DONE:    if (out_ready)                state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  // Outputs; the result is only visible while it is valid.
  always_comb begin
    out_valid = (state_reg == DONE);
    token_id  = '0;
    score     = '0;
    if (state_reg == DONE) begin
      token_id = best_id_reg;
      score    = best_score_reg;
    end
  end

  // in_ready is registered from the next state so it stays low throughout
  // reset and rises on the first clock after release.
  assign in_ready = in_ready_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_reg    <= 1'b0;
      row_cnt_reg     <= '0;
      vec_reg         <= '0;
      stage_valid_reg <= 1'b0;
      stage_id_reg    <= '0;
      stage_score_reg <= '0;
      best_id_reg     <= '0;
      best_score_reg  <= '0;
    end else begin
      in_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            vec_reg         <= {vector3, vector2, vector1, vector0};
            row_cnt_reg     <= '0;
            stage_valid_reg <= 1'b0;
          end
        end
        SCAN: begin
          if (!scan_last) begin
            stage_score_reg <= mac_score;
            stage_id_reg    <= row_cnt_reg[ID_W-1:0];
            stage_valid_reg <= 1'b1;
            row_cnt_reg     <= row_cnt_reg + ROW_CNT_W'(1);
          end else begin
            stage_valid_reg <= 1'b0;
          end
          // Row 0 seeds the running best; later rows need a strict win,
          // so ties keep the lower index.
          if (stage_valid_reg &&
              ((stage_id_reg == '0) || (stage_score_reg > best_score_reg))) begin
            best_score_reg <= stage_score_reg;
            best_id_reg    <= stage_id_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_token_unembedding.sv
module tb_token_unembedding;
  import token_unembedding_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DW-1:0]      vector0, vector1, vector2, vector3;
  logic                      out_valid;
  logic                      out_ready;
  logic [ID_W-1:0]           token_id;
  logic signed [SCORE_W-1:0] score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  token_unembedding dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vector0   (vector0),
    .vector1   (vector1),
    .vector2   (vector2),
    .vector3   (vector3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .token_id  (token_id),
    .score     (score)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accepts one vector, scrambles the inputs during the scan, measures the
  // latency to out_valid and checks the result. With complete=1 the
  // handshake is expected to finish on the first DONE cycle.
  task automatic run_vector(input string name,
                            input int v0, input int v1, input int v2, input int v3,
                            input int exp_id, input int exp_score,
                            input bit complete);
    int lat;
    @(negedge clk);
    vector0 = DW'(v0); vector1 = DW'(v1); vector2 = DW'(v2); vector3 = DW'(v3);
    in_valid = 1'b1;
    check({name, "_ready_before"}, 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vector0 = DW'($urandom); vector1 = DW'($urandom);
    vector2 = DW'($urandom); vector3 = DW'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    check({name, "_latency"}, lat, 17);
    check({name, "_token_id"}, 32'(token_id), exp_id);
    check({name, "_score"}, 32'(score), exp_score);
    $display("txn %s: vec=(%0d,%0d,%0d,%0d) token_id=%0d score=%0d latency=%0d",
             name, v0, v1, v2, v3, token_id, score, lat);
    if (complete) begin
      @(posedge clk);
      #1;
      check({name, "_in_ready_after"}, 32'(in_ready), 1);
      check({name, "_out_valid_after"}, 32'(out_valid), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vector0 = '0; vector1 = '0; vector2 = '0; vector3 = '0;

    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_clk", 32'(in_ready), 0);
    check("rst_token_id", 32'(token_id), 0);
    check("rst_score", 32'(score), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 1);

    run_vector("t1", 10, -5, 3, -7, 5, 800, 1'b1);
    run_vector("t2", 0, 0, 0, 0, 0, 0, 1'b1);
    run_vector("t3a", -128, -128, -128, -128, 0, 16384, 1'b1);
    run_vector("t3b", 127, 127, 127, 127, 15, 16256, 1'b1);
    run_vector("t4", 0, 4, 0, 0, 2, 128, 1'b1);

    // Test 5: back-pressure in DONE
    out_ready = 1'b0;
    run_vector("t5", -20, 6, -1, 50, 10, 2464, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    vector0 = 8'sd100; vector1 = 8'sd100; vector2 = 8'sd100; vector3 = 8'sd100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t5_hold_out_valid", 32'(out_valid), 1);
      check("t5_hold_token_id", 32'(token_id), 10);
      check("t5_hold_score", 32'(score), 2464);
      check("t5_hold_in_ready", 32'(in_ready), 0);
    end
    $display("txn t5_hold: 5 stalled cycles token_id=%0d score=%0d", token_id, score);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_release_in_ready", 32'(in_ready), 1);
    check("t5_release_out_valid", 32'(out_valid), 0);

    // Test 6: reset during SCAN at row 8
    @(negedge clk);
    vector0 = 8'sd10; vector1 = -8'sd5; vector2 = 8'sd3; vector3 = -8'sd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_abort_out_valid", 32'(out_valid), 0);
    check("t6_abort_in_ready", 32'(in_ready), 0);
    check("t6_abort_token_id", 32'(token_id), 0);
    check("t6_abort_score", 32'(score), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("t6_rst_out_valid", 32'(out_valid), 0);
    end
    $display("txn t6_abort: reset in scan, out_valid=%0d", out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_release_in_ready", 32'(in_ready), 1);
    run_vector("t6", 1, 1, 1, 1, 15, 128, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/token_unembedding.md
TOKEN_UNEMBEDDING -- requirements
Module: token_unembedding

Interface
REQ-001 Parameter: N_TOKENS, 16, vocabulary size; token_id width is log2(N_TOKENS)=4.
REQ-002 Parameter: D_MODEL, 4, embedding vector length.
REQ-003 Parameter: DW, 8, signed element width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  input vector valid.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 vector0..vector3  input  8 each  signed two's-complement embedding elements 0..3.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 token_id  output  4  index of best-matching token.
REQ-012 score  output  18  signed dot product of winning token.

Function
REQ-013 Embedding table SHALL be fixed: element k of token t = +32 if bit k of t is 1, else -32.
REQ-014 Score(t) SHALL be the signed sum over k of vector_k * EMB[t][k], computed at full 18-bit precision, with no saturation and no truncation.
REQ-015 The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-016 IDLE: in_ready=1; when in_valid && in_ready, capture vector0..3 into an internal register, clear the row counter, go to SCAN.
REQ-017 SCAN: in_ready=0; evaluate exactly one token row per cycle, rows 0..15 in ascending order.
REQ-018 Row 0 SHALL unconditionally initialise best_score and best_id.
REQ-019 For each later row, best_score and best_id SHALL update only if Score(t) > best_score (strictly greater), so ties resolve to the lowest index.
REQ-020 After row 15 is evaluated, the FSM SHALL go to DONE; out_valid rises exactly 17 cycles after the accepting edge.
REQ-021 DONE: out_valid=1; token_id and score are held stable until out_valid && out_ready, then the FSM returns to IDLE.
REQ-022 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE, and input changes during SCAN or DONE SHALL not affect the result.
REQ-023 If out_ready is already high when DONE is entered, the handshake SHALL complete on that first DONE cycle, and in_ready SHALL be 1 on the next cycle.
REQ-024 Back-to-back throughput SHALL be one result per 19 cycles minimum (accept + 16 scan + done + idle).

Reset
REQ-025 While rst_n=0: FSM=IDLE, in_ready=0, out_valid=0, token_id=0, score=0, and the row counter, captured vector and best registers are all 0.
REQ-026 in_ready SHALL assert in the first cycle after rst_n deasserts.
REQ-027 Reset asserted during SCAN or DONE SHALL abort the operation immediately; no partial result is ever presented.

Structure
REQ-028 A shared package SHALL hold N_TOKENS, D_MODEL, DW, the score width (18), the state enum, and the embedding-table function (so token_embedding can share it).
REQ-029 One sub-module, token_score_mac, SHALL compute Score for one row combinationally (4 signed multiplies plus an adder tree); the FSM, counter and argmax live in token_unembedding.

Verification
REQ-030 Test 1: vector=(+10,-5,+3,-7) -> token_id=5, score=800, out_valid 17 cycles after acceptance.
REQ-031 Test 2: vector=(0,0,0,0) -> all scores tie at 0 -> token_id=0, score=0.
REQ-032 Test 3: vector=(-128,-128,-128,-128) -> token_id=0, score=16384; vector=(127,127,127,127) -> token_id=15, score=16256.
REQ-033 Test 4: tie case vector=(0,+4,0,0) -> token_id=2, score=128 (lowest of the tied tokens 2,3,6,7,10,11,14,15).
REQ-034 Test 5: hold out_ready=0 for 5 cycles in DONE -> token_id and score stable, in_ready=0, a new in_valid is ignored; release out_ready -> IDLE next cycle.
REQ-035 Test 6: assert rst_n=0 in SCAN row 8 -> out_valid stays 0 and all outputs are 0; after release, a new vector (+1,+1,+1,+1) -> token_id=15, score=128.
